// File: rtl/int_sqrt_rr_arbiter_if.sv
// Request/engine/response bundle for the shared integer square-root arbiter.
// The arbiter uses the slave modport; the client/engine side uses master.
interface int_sqrt_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      eng_start;
    logic [DATA_W-1:0]         eng_a;
    logic                      eng_done;
    logic [DATA_W-1:0]         eng_sqrt;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_sqrt;
    logic                      rsp_err;
    logic                      rsp_ready;

    modport slave (
        input  req_valid, req_a, eng_done, eng_sqrt, rsp_ready,
        output req_ready, eng_start, eng_a, rsp_valid, rsp_id, rsp_sqrt, rsp_err
    );

    modport master (
        output req_valid, req_a, eng_done, eng_sqrt, rsp_ready,
        input  req_ready, eng_start, eng_a, rsp_valid, rsp_id, rsp_sqrt, rsp_err
    );
endinterface

// File: rtl/int_sqrt_rr_arbiter.sv
// Round-robin arbiter sharing one integer square-root engine among NUM_REQ
// requesters. One job in flight: accept -> start pulse -> wait for done
// (or watchdog abort) -> hold response until the consumer takes it.
module int_sqrt_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   clr,
    int_sqrt_rr_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    state_t            state_q,     state_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]   id_q,        id_d;
    logic [DATA_W-1:0] eng_a_q,     eng_a_d;
    logic              eng_start_q, eng_start_d;
    logic [WD_W-1:0]   wd_q,        wd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_sqrt_q,  rsp_sqrt_d;
    logic              rsp_err_q,   rsp_err_d;

    logic [ID_W-1:0]    grant_s;
    logic               any_req_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [DATA_W-1:0]  operand_s;

    // Round-robin grant; the one-hot accept is only offered while idle.
    always_comb begin
        grant_s   = rr_pick(bus.req_valid, rr_ptr_q);
        any_req_s = |bus.req_valid;
        operand_s = bus.req_a[grant_s*DATA_W +: DATA_W];
        grant_oh_s = '0;
        if ((state_q == ST_IDLE) && any_req_s) begin
            grant_oh_s = NUM_REQ'(1'b1) << grant_s;
        end else begin
            grant_oh_s = '0;
        end
    end

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        eng_a_d     = eng_a_q;
        eng_start_d = 1'b0;
        wd_d        = wd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sqrt_d  = rsp_sqrt_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    eng_a_d     = operand_s;
                    id_d        = grant_s;
                    rr_ptr_d    = (grant_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_s + ID_W'(1);
                    eng_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A done on the final watchdog cycle still counts as success.
                if (bus.eng_done) begin
                    rsp_sqrt_d  = bus.eng_sqrt;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_sqrt_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; clr drops any job in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            eng_a_q     <= '0;
            eng_start_q <= 1'b0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sqrt_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            eng_a_q     <= eng_a_d;
            eng_start_q <= eng_start_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sqrt_q  <= rsp_sqrt_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = grant_oh_s;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_a     = eng_a_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sqrt  = rsp_sqrt_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
